// File: rtl/interrupt_controller.sv
`default_nettype none
// ============================================================================
// Module   : interrupt_controller
// Brief    : Edge-captured, maskable 4-source interrupt sequencer with IRQ /
//            Ack / Return handshake and vector generation. Fixed priority by
//            default; define INTC_ROUND_ROBIN_EN for rotating priority.
// Revision : 1.0 - initial release
// ============================================================================
module interrupt_controller #(
    parameter int               NUM_SRC    = 4,
    parameter int               VEC_W      = 16,
    parameter logic [VEC_W-1:0] VEC_BASE   = 16'h0100,
    parameter int               VEC_STRIDE = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] i_sw,
    input  logic               i_mask_write,
    input  logic [NUM_SRC-1:0] i_mask_in,
    input  logic               i_int_ack,
    input  logic               i_int_return,
    output logic               o_irq,
    output logic [VEC_W-1:0]   o_vector,
    output logic [1:0]         o_src_id,
    output logic [NUM_SRC-1:0] o_pending,
    output logic [NUM_SRC-1:0] o_mask,
    output logic               o_in_service
);

    localparam logic [VEC_W-1:0] c_stride = VEC_W'(VEC_STRIDE);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    state_t             r_state;
    logic [NUM_SRC-1:0] r_hist;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] r_mask;
    logic [1:0]         r_src_id;
    logic [VEC_W-1:0]   r_vector;
    logic               r_irq;
    logic               r_in_service;

    logic [NUM_SRC-1:0] w_edge;
    logic [NUM_SRC-1:0] w_cand;
    logic [NUM_SRC-1:0] w_ack_clr;
    logic               w_ack_take;
    logic [1:0]         w_start;
    logic [1:0]         w_idx;
    logic [1:0]         w_win;
    logic               w_found;
    logic [VEC_W-1:0]   w_vec;

    assign w_edge     = i_sw & ~r_hist;
    assign w_cand     = r_pending & ~r_mask;
    assign w_ack_take = (r_state == S_REQ) && i_int_ack;
    // Ack clear is applied before the new edges are OR-ed in, so a coincident edge survives
    assign w_ack_clr  = w_ack_take ? (NUM_SRC'(1) << r_src_id) : '0;

`ifdef INTC_ROUND_ROBIN_EN
    logic [1:0] r_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= 2'd0;
        end else if (w_ack_take) begin
            r_ptr <= r_src_id + 2'd1;
        end
    end

    assign w_start = r_ptr;
`else
    assign w_start = 2'd0;
`endif

    // Circular search from w_start; the first enabled pending source wins
    always_comb begin
        w_found = 1'b0;
        w_win   = 2'd0;
        w_idx   = 2'd0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_idx = w_start + i[1:0];
            if (!w_found && w_cand[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign w_vec = VEC_BASE + ({{(VEC_W-2){1'b0}}, w_win} * c_stride);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_hist       <= '0;
            r_pending    <= '0;
            r_mask       <= '1;
            r_src_id     <= 2'd0;
            r_vector     <= '0;
            r_irq        <= 1'b0;
            r_in_service <= 1'b0;
        end else begin
            r_hist    <= i_sw;
            r_pending <= (r_pending & ~w_ack_clr) | w_edge;
            if (i_mask_write) begin
                r_mask <= i_mask_in;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_src_id <= w_win;
                        r_vector <= w_vec;
                        r_irq    <= 1'b1;
                        r_state  <= S_REQ;
                    end
                end
                S_REQ: begin
                    // Request is held even if the winner gets masked meanwhile
                    if (i_int_ack) begin
                        r_irq        <= 1'b0;
                        r_in_service <= 1'b1;
                        r_state      <= S_SERVICE;
                    end
                end
                S_SERVICE: begin
                    if (i_int_return) begin
                        r_in_service <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_irq        <= 1'b0;
                    r_in_service <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    assign o_irq        = r_irq;
    assign o_vector     = r_vector;
    assign o_src_id     = r_src_id;
    assign o_pending    = r_pending;
    assign o_mask       = r_mask;
    assign o_in_service = r_in_service;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_interrupt_controller
// Brief    : Self-checking bench: directed vector table, reset sequences and a
//            randomized run against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_interrupt_controller;

    logic        clk;
    logic        rst;
    logic [3:0]  i_sw;
    logic        i_mask_write;
    logic [3:0]  i_mask_in;
    logic        i_int_ack;
    logic        i_int_return;
    logic        o_irq;
    logic [15:0] o_vector;
    logic [1:0]  o_src_id;
    logic [3:0]  o_pending;
    logic [3:0]  o_mask;
    logic        o_in_service;

    int n_checks = 0;
    int n_pass   = 0;

    interrupt_controller dut (
        .clk          (clk),
        .rst          (rst),
        .i_sw         (i_sw),
        .i_mask_write (i_mask_write),
        .i_mask_in    (i_mask_in),
        .i_int_ack    (i_int_ack),
        .i_int_return (i_int_return),
        .o_irq        (o_irq),
        .o_vector     (o_vector),
        .o_src_id     (o_src_id),
        .o_pending    (o_pending),
        .o_mask       (o_mask),
        .o_in_service (o_in_service)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed observation: {irq, in_service, pending, mask, src_id, vector}
    function automatic logic [27:0] pk(input logic irq, input logic ins, input logic [3:0] pend,
                                       input logic [3:0] mask, input logic [1:0] src,
                                       input logic [15:0] vec);
        return {irq, ins, pend, mask, src, vec};
    endfunction

    function automatic logic [27:0] observe();
        return pk(o_irq, o_in_service, o_pending, o_mask, o_src_id, o_vector);
    endfunction

    task automatic check(input string name, input logic [27:0] act, input logic [27:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got irq=%b ins=%b pend=%h mask=%h src=%0d vec=%h, expected irq=%b ins=%b pend=%h mask=%h src=%0d vec=%h",
                     name, act[27], act[26], act[25:22], act[21:18], act[17:16], act[15:0],
                     exp[27], exp[26], exp[25:22], exp[21:18], exp[17:16], exp[15:0]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] sw, input logic mw, input logic [3:0] mi,
                         input logic ack, input logic ret);
        i_sw         = sw;
        i_mask_write = mw;
        i_mask_in    = mi;
        i_int_ack    = ack;
        i_int_return = ret;
    endtask

    // ---------------- behavioural reference model ----------------
    // phase: 0 = waiting for a source, 1 = requesting, 2 = ISR running
    int         m_phase;
    logic [3:0] m_hist, m_pend, m_mask;
    logic [1:0] m_src;
    logic [15:0] m_vec;
    int         m_next_start;

    function automatic int pick(input logic [3:0] cand, input int start);
        for (int k = 0; k < 4; k++) begin
            if (cand[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_hist = 4'h0; m_pend = 4'h0; m_mask = 4'hF;
        m_src = 2'd0; m_vec = 16'h0000; m_next_start = 0;
    endtask

    task automatic model_clock(input logic [3:0] sw, input logic mw, input logic [3:0] mi,
                               input logic ack, input logic ret);
        logic [3:0] new_pend;
        int         w;
        new_pend = m_pend;
        if (m_phase == 1 && ack) new_pend[m_src] = 1'b0;
        new_pend = new_pend | (sw & ~m_hist);
        if (m_phase == 0) begin
            w = pick(m_pend & ~m_mask, m_next_start);
            if (w >= 0) begin
                m_src   = w[1:0];
                m_vec   = 16'h0100 + 16'(w * 8);
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (ack) begin
                m_phase = 2;
`ifdef INTC_ROUND_ROBIN_EN
                m_next_start = (int'(m_src) + 1) % 4;
`endif
            end
        end else begin
            if (ret) m_phase = 0;
        end
        m_pend = new_pend;
        m_hist = sw;
        if (mw) m_mask = mi;
    endtask

    function automatic logic [27:0] model_obs();
        return pk(m_phase == 1, m_phase == 2, m_pend, m_mask, m_src, m_vec);
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [3:0]  sw;
        logic        mw;
        logic [3:0]  mi;
        logic        ack;
        logic        ret;
        logic [27:0] exp;
    } vec_t;

    vec_t tbl [25];

    initial begin
        logic [3:0] sw_r;
        logic       mw_r, ack_r, ret_r;
        logic [3:0] mi_r;

        tbl[0]  = '{4'h1, 1'b0, 4'h0, 1'b0, 1'b0, pk(0, 0, 4'h1, 4'hF, 2'd0, 16'h0000)};
        tbl[1]  = '{4'h1, 1'b0, 4'h0, 1'b0, 1'b0, pk(0, 0, 4'h1, 4'hF, 2'd0, 16'h0000)};
        tbl[2]  = '{4'h1, 1'b1, 4'h0, 1'b0, 1'b0, pk(0, 0, 4'h1, 4'h0, 2'd0, 16'h0000)};
        tbl[3]  = '{4'h1, 1'b0, 4'h0, 1'b0, 1'b0, pk(1, 0, 4'h1, 4'h0, 2'd0, 16'h0100)};
        tbl[4]  = '{4'h0, 1'b0, 4'h0, 1'b1, 1'b0, pk(0, 1, 4'h0, 4'h0, 2'd0, 16'h0100)};
        tbl[5]  = '{4'h0, 1'b0, 4'h0, 1'b0, 1'b1, pk(0, 0, 4'h0, 4'h0, 2'd0, 16'h0100)};
        tbl[6]  = '{4'h0, 1'b0, 4'h0, 1'b1, 1'b0, pk(0, 0, 4'h0, 4'h0, 2'd0, 16'h0100)};
        tbl[7]  = '{4'hA, 1'b0, 4'h0, 1'b0, 1'b0, pk(0, 0, 4'hA, 4'h0, 2'd0, 16'h0100)};
        tbl[8]  = '{4'hA, 1'b0, 4'h0, 1'b0, 1'b0, pk(1, 0, 4'hA, 4'h0, 2'd1, 16'h0108)};
        tbl[9]  = '{4'h0, 1'b0, 4'h0, 1'b1, 1'b1, pk(0, 1, 4'h8, 4'h0, 2'd1, 16'h0108)};
        tbl[10] = '{4'h4, 1'b0, 4'h0, 1'b0, 1'b0, pk(0, 1, 4'hC, 4'h0, 2'd1, 16'h0108)};
        tbl[11] = '{4'h4, 1'b0, 4'h0, 1'b0, 1'b1, pk(0, 0, 4'hC, 4'h0, 2'd1, 16'h0108)};
        tbl[12] = '{4'h4, 1'b0, 4'h0, 1'b0, 1'b0, pk(1, 0, 4'hC, 4'h0, 2'd2, 16'h0110)};
        tbl[13] = '{4'h0, 1'b0, 4'h0, 1'b1, 1'b0, pk(0, 1, 4'h8, 4'h0, 2'd2, 16'h0110)};
        tbl[14] = '{4'h0, 1'b0, 4'h0, 1'b0, 1'b1, pk(0, 0, 4'h8, 4'h0, 2'd2, 16'h0110)};
        tbl[15] = '{4'h0, 1'b0, 4'h0, 1'b0, 1'b0, pk(1, 0, 4'h8, 4'h0, 2'd3, 16'h0118)};
        tbl[16] = '{4'h1, 1'b0, 4'h0, 1'b1, 1'b0, pk(0, 1, 4'h1, 4'h0, 2'd3, 16'h0118)};
        tbl[17] = '{4'h0, 1'b0, 4'h0, 1'b0, 1'b1, pk(0, 0, 4'h1, 4'h0, 2'd3, 16'h0118)};
        tbl[18] = '{4'h0, 1'b0, 4'h0, 1'b0, 1'b0, pk(1, 0, 4'h1, 4'h0, 2'd0, 16'h0100)};
        tbl[19] = '{4'h1, 1'b0, 4'h0, 1'b1, 1'b0, pk(0, 1, 4'h1, 4'h0, 2'd0, 16'h0100)};
        tbl[20] = '{4'h0, 1'b0, 4'h0, 1'b0, 1'b1, pk(0, 0, 4'h1, 4'h0, 2'd0, 16'h0100)};
        tbl[21] = '{4'h0, 1'b0, 4'h0, 1'b0, 1'b0, pk(1, 0, 4'h1, 4'h0, 2'd0, 16'h0100)};
        tbl[22] = '{4'h0, 1'b1, 4'hF, 1'b0, 1'b0, pk(1, 0, 4'h1, 4'hF, 2'd0, 16'h0100)};
        tbl[23] = '{4'h0, 1'b0, 4'h0, 1'b1, 1'b0, pk(0, 1, 4'h0, 4'hF, 2'd0, 16'h0100)};
        tbl[24] = '{4'h0, 1'b0, 4'h0, 1'b0, 1'b1, pk(0, 0, 4'h0, 4'hF, 2'd0, 16'h0100)};

        drive(4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        check("reset_state", observe(), pk(0, 0, 4'h0, 4'hF, 2'd0, 16'h0000));
        rst = 1'b0;

        for (int r = 0; r < 25; r++) begin
            drive(tbl[r].sw, tbl[r].mw, tbl[r].mi, tbl[r].ack, tbl[r].ret);
            tick();
            check($sformatf("vec_row%0d", r), observe(), tbl[r].exp);
        end

        // Asynchronous abort while a request is outstanding
        drive(4'h2, 1'b1, 4'h0, 1'b0, 1'b0);
        tick();
        check("rst_mid_setup", observe(), pk(0, 0, 4'h2, 4'h0, 2'd0, 16'h0100));
        drive(4'h2, 1'b0, 4'h0, 1'b0, 1'b0);
        tick();
        check("rst_mid_req", observe(), pk(1, 0, 4'h2, 4'h0, 2'd1, 16'h0108));
        #3 rst = 1'b1;
        #1;
        check("rst_async_abort", observe(), pk(0, 0, 4'h0, 4'hF, 2'd0, 16'h0000));
        #1 rst = 1'b0;
        // Source already high when reset releases counts as an edge
        tick();
        check("rst_release_edge", observe(), pk(0, 0, 4'h2, 4'hF, 2'd0, 16'h0000));

        // Randomized run against the reference model
        drive(4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        sw_r = 4'h0;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 2) == 0) sw_r = sw_r ^ 4'($urandom);
            mw_r  = ($urandom_range(0, 11) == 0);
            mi_r  = 4'($urandom) & 4'($urandom);
            ack_r = o_irq ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
            ret_r = ($urandom_range(0, 3) == 0);
            drive(sw_r, mw_r, mi_r, ack_r, ret_r);
            tick();
            model_clock(sw_r, mw_r, mi_r, ack_r, ret_r);
            check($sformatf("rand_cyc%0d", c), observe(), model_obs());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Sequences the switch interrupt sources (Sw0..Sw3) into a single processor interrupt request.
- Captures rising edges into pending bits and applies a software-writable mask.
- Picks one winner, presents IRQ with a vector address, and holds off further requests until the processor signals return from the ISR.
- Sits between the switch inputs/interrupt state register and the control unit's PC-select logic.

Parameters:
- NUM_SRC, 4, number of interrupt sources (Sw bus width); fixed at 4 for this design.
- VEC_W, 16, width of the vector address.
- VEC_BASE, 16'h0100, vector address of source 0.
- VEC_STRIDE, 8, address spacing between consecutive source vectors.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- CLR  in  1  asynchronous, active-high reset.
- Sw  in  NUM_SRC  raw interrupt source levels (bit i = Sw_i), already synchronous to CLK.
- Mask_Write  in  1  loads Mask_In into the mask register.
- Mask_In  in  NUM_SRC  new mask value; 1 = source disabled.
- Int_Ack  in  1  processor has taken the vector; valid only while IRQ=1.
- Int_Return  in  1  ISR complete; valid only while In_Service=1.
- IRQ  out  1  interrupt request to the control unit.
- Vector  out  VEC_W  ISR address = VEC_BASE + Src_ID*VEC_STRIDE.
- Src_ID  out  2  index of the current/last winning source.
- Pending  out  NUM_SRC  latched pending bits.
- Mask  out  NUM_SRC  current mask register.
- In_Service  out  1  high while an ISR is executing.

Behaviour:
- Reset (CLR=1, asynchronous):
  - State=IDLE; IRQ=0; In_Service=0.
  - Pending=0; Mask=4'hF (all disabled).
  - Src_ID=0; Vector=0; edge-detect history register=0.
  - A source already high when CLR releases therefore registers as an edge on the first clock.
- Edge detect: Pending[i] is set on any clock where Sw[i]=1 and the history bit is 0. History is updated every clock. Edges set Pending regardless of Mask or state.
- Mask: written on the clock where Mask_Write=1. The new value is used from the following cycle. Masking never clears Pending.
- FSM:
  - IDLE: if (Pending & ~Mask) != 0, latch the winner into Src_ID, drive Vector, then go to REQ. IRQ=1 from the next cycle. Otherwise stay in IDLE.
  - REQ: IRQ=1; Vector and Src_ID held stable. The request is not withdrawn even if the winner becomes masked. On Int_Ack: clear Pending[Src_ID], IRQ=0, In_Service=1, go to SERVICE.
  - SERVICE: IRQ=0. New edges still accumulate in Pending. On Int_Return: In_Service=0, go to IDLE. Arbitration may fire on the cycle after returning to IDLE.
- Priority (default): fixed; lowest index wins (Sw0 highest).
- Latency: a Sw edge sampled at clock N sets Pending at N. IRQ is high after clock N+1. A back-to-back request after Int_Return is issued at return+1.
- Simultaneous events:
  - New edge on Sw[Src_ID] in the same cycle as Int_Ack: set wins, so Pending stays 1.
  - Int_Ack outside REQ is ignored.
  - Int_Return outside SERVICE is ignored.
  - Int_Ack and Int_Return together in REQ: only Ack is acted on.
- Vector arithmetic is modulo 2^VEC_W with no overflow flag.
- CLR asserted in REQ or SERVICE aborts immediately to the reset values above.

Optional Feature:
- Macro: INTC_ROUND_ROBIN_EN.
- Defined: rotating priority. After source k is acknowledged, the search starts at (k+1) mod NUM_SRC. The rotation pointer resets to 0, so the first search starts at Sw0.
- Undefined: fixed priority as described above; no pointer logic is generated.

Test Plan:
- Reset/mask: CLR pulse, Sw=4'b0001 edge with Mask=4'hF -> Pending=4'b0001, IRQ stays 0. Write Mask_In=4'h0 -> IRQ=1 two cycles later, Src_ID=0, Vector=16'h0100.
- Handshake: in REQ pulse Int_Ack -> IRQ=0, In_Service=1, Pending[0]=0. Then pulse Int_Return -> In_Service=0, state IDLE.
- Priority: Mask=0, edges on Sw1 and Sw3 in the same cycle -> first Src_ID=1 (Vector 16'h0108). After Ack/Return -> Src_ID=3 (Vector 16'h0118). With INTC_ROUND_ROBIN_EN after servicing Sw1, Sw0+Sw2 pending -> Src_ID=2.
- Blocking: edge on Sw2 during SERVICE -> Pending[2]=1, IRQ=0 until Int_Return, then IRQ=1 one cycle after return.
- Simultaneous: new Sw0 edge in the same cycle as Int_Ack for Src_ID=0 -> Pending[0] remains 1. Stray Int_Ack in IDLE -> no state change.
- Reset mid-operation: assert CLR while IRQ=1 -> IRQ, In_Service and Pending=0, Mask=4'hF immediately, without waiting for a clock edge.
